// File: rtl/tape_wav_player.sv
// rtl/tape_wav_player.sv - WAV cassette image loader and real-time replayer
//
// Purpose: captures a canonical WAV image from the ioctl download stream into
// a byte RAM, validates its header, then replays channel 0 at the file's
// sample rate (or FAST_MULT times faster) as a signed 16-bit sample and a
// hysteresis-sliced tape level.
//
// Ports:
//   sysclk, reset             clock, synchronous active-high reset
//   ioctl_download/index/wr/addr/dout   download byte stream in
//   ioctl_wait                always 0, one byte per cycle is accepted
//   motor, rewind, fast       playback controls (rewind acts on rising edge)
//   tape_bit, audio           sliced level and signed sample out
//   playing, loaded, err      status out
module tape_wav_player #(
    parameter int CLK_HZ    = 50000000,
    parameter int ADDR_W    = 19,
    parameter int INDEX     = 1,
    parameter int MAX_RATE  = 48000,
    parameter int FAST_MULT = 8,
    parameter int HYST      = 1024
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    input  logic        motor,
    input  logic        rewind,
    input  logic        fast,
    output logic        tape_bit,
    output logic [15:0] audio,
    output logic        playing,
    output logic        loaded,
    output logic        err
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] HDR_LEN = (ADDR_W+1)'(44);
    localparam logic signed [15:0] HYST_P = 16'(HYST);

    typedef enum logic [2:0] {S_EMPTY, S_LOAD, S_CHECK, S_READY, S_PLAY, S_ERROR} state_t;
    state_t state, state_nx;

    logic [7:0]        ram [DEPTH];
    logic [7:0]        ram_q;
    logic              active, active_q, dl_rise, dl_fall, in_range, wr_en;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic [ADDR_W:0]   count, count_base, wr_top, end_pos, end_calc, pos, pos_nf;
    logic [31:0]       riff, wave, dtag, rate, dlen, step, acc, acc_sum;
    logic [15:0]       chans, bits;
    logic [5:0]        hdr_a;
    logic [4:0]        lane;
    logic [3:0]        lane16;
    logic [32:0]       len_end;
    logic              hdr_ok, rewind_q, rew_act, tick_hit, tick, frame_fits, frame_done;
    logic              fetching;
    logic [2:0]        c, bpf;
    logic [7:0]        b0, b1, b0_eff, hi_eff;
    logic [15:0]       sample_new, audio_r;
    logic              tape_r;

    assign active   = ioctl_download && (ioctl_index == 8'(INDEX));
    assign dl_rise  = active && !active_q;
    assign dl_fall  = !active && active_q;
    assign in_range = (ioctl_addr >> ADDR_W) == 25'd0;
    assign wr_en    = active && ioctl_wr && in_range;
    assign wr_addr  = ioctl_addr[ADDR_W-1:0];

    // A new download restarts the byte count even if its first byte lands
    // in the same cycle the download is first seen.
    assign count_base = dl_rise ? '0 : count;
    assign wr_top     = (ADDR_W+1)'({1'b0, wr_addr}) + (ADDR_W+1)'(1);

    assign hdr_a  = ioctl_addr[5:0];
    assign lane   = {hdr_a[1:0], 3'b000};
    assign lane16 = {hdr_a[0], 3'b000};

    always_ff @(posedge sysclk) begin
        if (wr_en) ram[wr_addr] <= ioctl_dout;
        ram_q <= ram[rd_addr];
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            count <= '0;
            riff <= '0; wave <= '0; dtag <= '0; rate <= '0; dlen <= '0;
            chans <= '0; bits <= '0;
        end else begin
            if (dl_rise || wr_en)
                count <= (wr_en && wr_top > count_base) ? wr_top : count_base;
            if (wr_en && ioctl_addr < 25'd44) begin
                if (hdr_a < 6'd4)                        riff[lane +: 8]    <= ioctl_dout;
                else if (hdr_a >= 6'd8  && hdr_a < 6'd12) wave[lane +: 8]    <= ioctl_dout;
                else if (hdr_a >= 6'd22 && hdr_a < 6'd24) chans[lane16 +: 8] <= ioctl_dout;
                else if (hdr_a >= 6'd24 && hdr_a < 6'd28) rate[lane +: 8]    <= ioctl_dout;
                else if (hdr_a >= 6'd34 && hdr_a < 6'd36) bits[lane16 +: 8]  <= ioctl_dout;
                else if (hdr_a >= 6'd36 && hdr_a < 6'd40) dtag[lane +: 8]    <= ioctl_dout;
                else if (hdr_a >= 6'd40)                  dlen[lane +: 8]    <= ioctl_dout;
            end
        end
    end

    // Magic words as they appear after little-endian assembly of each 4-byte tag.
    assign hdr_ok = (riff == 32'h46464952) && (wave == 32'h45564157) &&
                    (dtag == 32'h61746164) && (chans == 16'd1 || chans == 16'd2) &&
                    (bits == 16'd8 || bits == 16'd16) && (rate != 32'd0) &&
                    (rate <= 32'(MAX_RATE)) && (count >= HDR_LEN);

    assign len_end  = {1'b0, dlen} + 33'd44;
    assign end_calc = (len_end < 33'(count)) ? (ADDR_W+1)'(len_end) : count;

    assign bpf    = 3'd1 << (2'(chans[1]) + 2'(bits[4]));
    assign pos_nf = pos + (ADDR_W+1)'(bpf);
    assign rd_addr = ADDR_W'(pos) + ADDR_W'(c);

    assign step     = fast ? rate * 32'(FAST_MULT) : rate;
    assign acc_sum  = acc + step;
    assign tick_hit = acc_sum >= 32'(CLK_HZ);

    assign rew_act    = rewind && !rewind_q && (state == S_READY || state == S_PLAY);
    assign tick       = (state == S_PLAY) && motor && tick_hit && !rew_act;
    assign frame_fits = pos_nf <= end_pos;
    assign frame_done = (state == S_PLAY) && motor && fetching && (c == bpf) && !rew_act && !dl_rise;

    // ram_q holds byte c-1 of the frame while fetching; the final byte is
    // still in ram_q rather than in b0/b1 when the frame completes.
    assign b0_eff     = (c == 3'd1) ? ram_q : b0;
    assign hi_eff     = (c == 3'd2) ? ram_q : b1;
    assign sample_new = bits[4] ? {hi_eff, b0_eff} : {b0_eff ^ 8'h80, 8'h00};

    always_comb begin
        state_nx = state;
        case (state)
            S_EMPTY, S_ERROR: state_nx = state;
            S_LOAD:  if (dl_fall) state_nx = S_CHECK;
            S_CHECK: state_nx = hdr_ok ? S_READY : S_ERROR;
            S_READY: if (motor && pos < end_pos) state_nx = S_PLAY;
            S_PLAY: begin
                if (!motor)                  state_nx = S_READY;
                else if (tick && !frame_fits) state_nx = S_READY;
            end
            default: state_nx = S_EMPTY;
        endcase
        if (dl_rise) state_nx = S_LOAD;
    end

    always_ff @(posedge sysclk) begin
        if (reset) state <= S_EMPTY;
        else       state <= state_nx;
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            active_q <= 1'b0; rewind_q <= 1'b0;
            pos <= HDR_LEN; acc <= '0; end_pos <= '0;
            fetching <= 1'b0; c <= '0; b0 <= '0; b1 <= '0;
            audio_r <= '0; tape_r <= 1'b0;
        end else begin
            active_q <= active;
            rewind_q <= rewind;
            if (state == S_CHECK) end_pos <= end_calc;

            if (dl_rise || rew_act) begin
                pos <= HDR_LEN; acc <= '0; fetching <= 1'b0; c <= '0;
            end else if (state == S_PLAY && motor) begin
                acc <= tick_hit ? acc_sum - 32'(CLK_HZ) : acc_sum;
                if (tick && frame_fits) begin
                    fetching <= 1'b1; c <= 3'd1;
                end else if (fetching) begin
                    if (c == 3'd1) b0 <= ram_q;
                    if (c == 3'd2) b1 <= ram_q;
                    if (frame_done) begin
                        fetching <= 1'b0; c <= '0; pos <= pos_nf;
                    end else begin
                        c <= c + 3'd1;
                    end
                end
            end else begin
                // Motor stop abandons a partial fetch; pos still points at it.
                fetching <= 1'b0; c <= '0;
            end

            if (state_nx != S_PLAY) audio_r <= '0;
            else if (frame_done)    audio_r <= sample_new;

            if (frame_done) begin
                if ($signed(sample_new) > HYST_P)       tape_r <= 1'b1;
                else if ($signed(sample_new) < -HYST_P) tape_r <= 1'b0;
            end
        end
    end

    assign ioctl_wait = 1'b0;
    assign audio      = audio_r;
    assign tape_bit   = tape_r;
    assign playing    = (state == S_PLAY);
    assign loaded     = (state == S_READY) || (state == S_PLAY);
    assign err        = (state == S_ERROR);
endmodule
